// File: rtl/trace_backpressure_buf_pkg.sv
// Shared trace definitions: packet tag values, backpressure FSM state and the
// overflow packet builder used by the trace backpressure stage.
package trace_pkg;

  localparam logic TRACE_TAG_SAMPLE = 1'b0;
  localparam logic TRACE_TAG_OVF    = 1'b1;
  localparam int   TRACE_MAX_W      = 64;

  typedef enum logic {PASS = 1'b0, LOSS = 1'b1} trace_state_e;

  // Zero-extended count with the overflow tag at bit tag_pos; caller truncates
  // the result to {tag, payload} width.
  function automatic logic [TRACE_MAX_W:0] trace_ovf_pkt(input logic [TRACE_MAX_W-1:0] cnt,
                                                         input logic [6:0]             tag_pos);
    logic [TRACE_MAX_W:0] pkt;
    pkt          = {1'b0, cnt};
    pkt[tag_pos] = TRACE_TAG_OVF;
    return pkt;
  endfunction

endpackage

// File: rtl/trace_backpressure_buf_if.sv
// Sample-source / trace-FIFO handshake bundle for the backpressure stage.
interface trace_backpressure_buf_if #(parameter int sample_width_p = 16);
  logic [sample_width_p-1:0] sample_data;
  logic                      sample_valid;
  logic [sample_width_p:0]   fifo_data;
  logic                      fifo_valid;
  logic                      fifo_ready;
  logic                      in_loss;

  modport master (output sample_data, sample_valid, fifo_ready,
                  input  fifo_data, fifo_valid, in_loss);
  modport slave  (input  sample_data, sample_valid, fifo_ready,
                  output fifo_data, fifo_valid, in_loss);
endinterface

// File: rtl/trace_backpressure_buf_fifo.sv
// Registered synchronous FIFO without bypass; head is the registered entry at
// the read pointer, so a push becomes visible one cycle later at the earliest.
module trace_sync_fifo #(
  parameter int width_p = 16,
  parameter int depth_p = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [width_p-1:0] push_data,
  input  logic               pop,
  output logic               full,
  output logic               empty,
  output logic [width_p-1:0] head
);
  localparam int AW = $clog2(depth_p);

  logic [depth_p-1:0][width_p-1:0] mem_q, mem_d;
  logic [AW-1:0]                   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]                     cnt_q, cnt_d;

  assign full  = (cnt_q == (AW+1)'(depth_p));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because depth_p is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

endmodule

// File: rtl/trace_backpressure_buf.sv
// Trace backpressure stage: buffers samples through short stalls, then drops
// and counts them, reporting the loss with one in-order overflow packet.
module trace_backpressure_buf
  import trace_pkg::*;
#(
  parameter int sample_width_p  = 16,
  parameter int counter_width_p = 16,
  parameter int depth_p         = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  trace_backpressure_buf_if.slave  bus
);

  if (sample_width_p < counter_width_p || counter_width_p > TRACE_MAX_W) begin : g_bad_width
    $error("trace_backpressure_buf: counter_width_p must fit in sample_width_p");
  end
  if (depth_p < 2 || (depth_p & (depth_p - 1)) != 0) begin : g_bad_depth
    $error("trace_backpressure_buf: depth_p must be a power of two >= 2");
  end

  trace_state_e               state_q, state_d;
  logic [counter_width_p-1:0] ctr_q, ctr_d;
  logic                       push, pop, full, empty;
  logic [sample_width_p-1:0]  head;
  logic                       ovf_pkt, accept;

  trace_sync_fifo #(.width_p(sample_width_p), .depth_p(depth_p)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.sample_data),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  // Overflow packet is only presented once every pre-drop sample has drained.
  assign ovf_pkt        = (state_q == LOSS) && empty;
  assign bus.fifo_valid = !empty || (state_q == LOSS);
  assign bus.in_loss    = (state_q == LOSS);
  assign accept         = bus.fifo_valid && bus.fifo_ready;
  assign pop            = accept && !empty;

  always_comb begin
    bus.fifo_data = '0;
    if (ovf_pkt)
      bus.fifo_data = (sample_width_p+1)'(trace_ovf_pkt(TRACE_MAX_W'(ctr_q), 7'(sample_width_p)));
    else if (!empty)
      bus.fifo_data = {TRACE_TAG_SAMPLE, head};
  end

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    push    = 1'b0;
    if (state_q == PASS) begin
      if (bus.sample_valid) begin
        if (!full || pop) begin
          push = 1'b1;
        end else begin
          ctr_d   = counter_width_p'(1);
          state_d = LOSS;
        end
      end
    end else if (accept && ovf_pkt) begin
      // The sample arriving with the accepted packet starts the new PASS epoch.
      ctr_d   = '0;
      state_d = PASS;
      push    = bus.sample_valid;
    end else if (bus.sample_valid && ctr_q != '1) begin
      ctr_d = ctr_q + counter_width_p'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PASS;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
    end
  end

endmodule

// File: tb/tb_trace_backpressure_buf.sv
// Directed bench for trace_backpressure_buf: a default instance plus a
// 4-bit-counter instance for the saturation case.
module tb_trace_backpressure_buf;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  trace_backpressure_buf_if #(.sample_width_p(16)) b0 ();
  trace_backpressure_buf_if #(.sample_width_p(16)) b1 ();

  trace_backpressure_buf #(.sample_width_p(16), .counter_width_p(16), .depth_p(4)) dut0 (
    .clk (clk), .rst (rst), .bus (b0.slave));
  trace_backpressure_buf #(.sample_width_p(16), .counter_width_p(4), .depth_p(4)) dut1 (
    .clk (clk), .rst (rst), .bus (b1.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic drv0(input logic v, input logic [15:0] d, input logic r);
    b0.sample_valid = v;
    b0.sample_data  = d;
    b0.fifo_ready   = r;
  endtask

  task automatic out0(input string tag, input logic v, input logic [16:0] d, input logic l);
    chk({tag, "_valid"}, 32'(b0.fifo_valid), 32'(v));
    if (v) chk({tag, "_data"}, 32'(b0.fifo_data), 32'(d));
    chk({tag, "_loss"}, 32'(b0.in_loss), 32'(l));
  endtask

  initial begin
    drv0(1'b0, 16'h0, 1'b0);
    b1.sample_valid = 1'b0;
    b1.sample_data  = '0;
    b1.fifo_ready   = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // reset state
    out0("rst", 1'b0, 17'h0, 1'b0);
    chk("rst_data", 32'(b0.fifo_data), 32'h0);

    // 1: three samples with ready=1
    drv0(1'b1, 16'h0011, 1'b1); tick(); out0("t1_a", 1'b1, 17'h00011, 1'b0);
    drv0(1'b1, 16'h0022, 1'b1); tick(); out0("t1_b", 1'b1, 17'h00022, 1'b0);
    drv0(1'b1, 16'h0033, 1'b1); tick(); out0("t1_c", 1'b1, 17'h00033, 1'b0);
    drv0(1'b0, 16'h0,    1'b1); tick(); out0("t1_end", 1'b0, 17'h0, 1'b0);

    // 2: stall, 7 samples, 3 dropped
    for (int i = 1; i <= 4; i++) begin
      drv0(1'b1, 16'(i), 1'b0); tick();
    end
    out0("t2_full", 1'b1, 17'h00001, 1'b0);
    drv0(1'b1, 16'd5, 1'b0); tick(); out0("t2_drop", 1'b1, 17'h00001, 1'b1);
    drv0(1'b1, 16'd6, 1'b0); tick();
    drv0(1'b1, 16'd7, 1'b0); tick(); out0("t2_hold", 1'b1, 17'h00001, 1'b1);
    drv0(1'b0, 16'h0, 1'b1);
    for (int i = 2; i <= 4; i++) begin
      tick(); out0("t2_drain", 1'b1, 17'(i), 1'b1);
    end
    tick(); out0("t2_ovf", 1'b1, 17'h10003, 1'b1);
    tick(); out0("t2_after", 1'b0, 17'h0, 1'b0);

    // 5: full buffer, push and pop together
    for (int i = 0; i < 4; i++) begin
      drv0(1'b1, 16'h0051 + 16'(i), 1'b0); tick();
    end
    drv0(1'b1, 16'h0055, 1'b1);
    out0("t5_head", 1'b1, 17'h00051, 1'b0);
    tick(); out0("t5_a", 1'b1, 17'h00052, 1'b0);
    drv0(1'b0, 16'h0, 1'b1);
    tick(); out0("t5_b", 1'b1, 17'h00053, 1'b0);
    tick(); out0("t5_c", 1'b1, 17'h00054, 1'b0);
    tick(); out0("t5_d", 1'b1, 17'h00055, 1'b0);
    tick(); out0("t5_end", 1'b0, 17'h0, 1'b0);

    // 4: overflow packet accepted together with a new sample
    for (int i = 0; i < 5; i++) begin
      drv0(1'b1, 16'h0061 + 16'(i), 1'b0); tick();
    end
    drv0(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    out0("t4_ovf", 1'b1, 17'h10001, 1'b1);
    drv0(1'b1, 16'hABCD, 1'b1); tick(); out0("t4_push", 1'b1, 17'h0ABCD, 1'b0);
    drv0(1'b0, 16'h0, 1'b1);    tick(); out0("t4_end", 1'b0, 17'h0, 1'b0);

    // 6: reset in LOSS with 2 buffered samples, ctr=5
    for (int i = 0; i < 5; i++) begin
      drv0(1'b1, 16'h0071 + 16'(i), 1'b0); tick();
    end
    drv0(1'b1, 16'h0076, 1'b1); tick();
    drv0(1'b1, 16'h0077, 1'b1); tick();
    drv0(1'b1, 16'h0078, 1'b0); tick();
    drv0(1'b1, 16'h0079, 1'b0); tick();
    out0("t6_pre", 1'b1, 17'h00073, 1'b1);
    drv0(1'b0, 16'h0, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    out0("t6_rst", 1'b0, 17'h0, 1'b0);
    chk("t6_rst_data", 32'(b0.fifo_data), 32'h0);
    drv0(1'b1, 16'h0042, 1'b1); tick(); out0("t6_smp", 1'b1, 17'h00042, 1'b0);
    drv0(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(); out0("t6_idle", 1'b0, 17'h0, 1'b0);
    end

    // 3: 4-bit counter saturates at 0xF
    for (int i = 0; i < 34; i++) begin
      b1.sample_valid = 1'b1;
      b1.sample_data  = 16'h0100 + 16'(i);
      b1.fifo_ready   = 1'b0;
      tick();
    end
    chk("t3_loss", 32'(b1.in_loss), 32'h1);
    b1.sample_valid = 1'b0;
    b1.fifo_ready   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_drain", 32'(b1.fifo_data), 32'h00100 + 32'(i));
      tick();
    end
    chk("t3_ovf_valid", 32'(b1.fifo_valid), 32'h1);
    chk("t3_ovf", 32'(b1.fifo_data), 32'h1000F);
    tick();
    chk("t3_after_loss", 32'(b1.in_loss), 32'h0);
    chk("t3_after_valid", 32'(b1.fifo_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
